vga_text: RTL and testbench

VGA_TEXT -- requirements
Module: vga_text

---
 rtl/vga_pkg.sv | 13 +
 rtl/vga_text_blink.sv | 14 +
 rtl/vga_text.sv | 86 ++++++++
 tb/tb_vga_text.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared text-mode geometry, pipeline latency and colour type for vga_text.
package vga_pkg;
  localparam int COLS      = 80;
  localparam int ROWS      = 25;
  localparam int LATENCY   = 5;
  localparam int H_VIS     = 640;
  localparam int V_VIS     = 400;
  localparam int BLINK_BIT = 4;
  typedef logic [2:0] rgb_t;
  function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return 11'(row) * 11'(COLS) + 11'(col);
  endfunction
endpackage

// File: rtl/vga_text_blink.sv
// vga_text_blink: 5-bit frame counter; blink phase is its BLINK_BIT.
module vga_text_blink
  import vga_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic frame,
  output logic phase
);
  logic [4:0] cnt_q, cnt_d;
  always_comb cnt_d = frame ? cnt_q + 5'd1 : cnt_q;
  always_ff @(posedge clock) cnt_q <= !reset_n ? '0 : cnt_d;
  assign phase = cnt_q[BLINK_BIT];
endmodule

// File: rtl/vga_text.sv
// vga_text: 80x25 text renderer, 8x16 cells, 5-cycle fetch pipeline to registered rgb.
// Optional underline cursor enabled by defining VGA_TEXT_CURSOR_EN.
module vga_text
  import vga_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        de,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame,
  output logic [10:0] vaddr,
  input  logic [15:0] vdata,
  output logic [11:0] faddr,
  input  logic [7:0]  fdata,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic        r,
  output logic        g,
  output logic        b
);
  logic [3:0]      de_q, de_d, cur_q, cur_d;
  logic [3:0][2:0] px_q, px_d;
  logic [1:0][3:0] line_q, line_d;
  logic [1:0][7:0] attr_q, attr_d;
  logic [10:0]     vaddr_q, vaddr_d;
  logic [11:0]     faddr_q, faddr_d;
  rgb_t            rgb_q, rgb_d, fg, bg;
  logic            phase, cur, on, unused_in;

  vga_text_blink u_blink (
    .clock  (clock),
    .reset_n(reset_n),
    .frame  (frame),
    .phase  (phase)
  );

`ifdef VGA_TEXT_CURSOR_EN
  assign cur       = x[9:3] == cursor_x && y[8:4] == cursor_y && &y[3:1];
  assign unused_in = y[9];
`else
  assign cur       = 1'b0;
  assign unused_in = ^{y[9], cursor_x, cursor_y};
`endif

  // Attribute is captured with faddr (n+3) so it meets fdata at the rgb stage.
  always_comb begin
    de_d    = {de_q[2:0], de};
    cur_d   = {cur_q[2:0], cur};
    px_d    = {px_q[2:0], x[2:0]};
    line_d  = {line_q[0], y[3:0]};
    attr_d  = {attr_q[0], vdata[15:8]};
    vaddr_d = de ? cell_addr(y[8:4], x[9:3]) : vaddr_q;
    faddr_d = de_q[1] ? {vdata[7:0], line_q[1]} : faddr_q;
    bg      = attr_q[1][6:4];
    fg      = attr_q[1][7] && phase ? bg : attr_q[1][2:0];
    on      = fdata[3'd7 - px_q[3]];
    rgb_d   = !de_q[3] ? '0 : cur_q[3] && phase ? attr_q[1][2:0] : on ? fg : bg;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      de_q    <= '0;
      cur_q   <= '0;
      px_q    <= '0;
      line_q  <= '0;
      attr_q  <= '0;
      vaddr_q <= '0;
      faddr_q <= '0;
      rgb_q   <= '0;
    end else begin
      de_q    <= de_d;
      cur_q   <= cur_d;
      px_q    <= px_d;
      line_q  <= line_d;
      attr_q  <= attr_d;
      vaddr_q <= vaddr_d;
      faddr_q <= faddr_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vaddr     = vaddr_q;
  assign faddr     = faddr_q;
  assign {r, g, b} = rgb_q;
endmodule

// File: tb/tb_vga_text.sv
// tb_vga_text: randomized self-checking bench for vga_text against a cell/glyph reference model.
module tb_vga_text;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0, de = 1'b0, frame = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [10:0] vaddr;
  logic [15:0] vdata;
  logic [11:0] faddr;
  logic [7:0]  fdata;
  logic [6:0]  cursor_x = '0;
  logic [4:0]  cursor_y = '0;
  logic        r, g, b;

  logic [15:0] ram [0:2047];
  logic [7:0]  font [0:4095];
  logic [2:0]  q [$];
  int tests = 0, fails = 0, fcnt = 0, cx = 0, cy = 0;
  bit rst_low = 0;

  vga_text dut (
    .clock(clk), .reset_n(reset_n), .de(de), .x(x), .y(y), .frame(frame),
    .vaddr(vaddr), .vdata(vdata), .faddr(faddr), .fdata(fdata),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vdata <= ram[vaddr];
    fdata <= font[faddr];
  end

  function automatic logic [2:0] model(input logic d, input int xx, input int yy);
    int col, row, ln, bt;
    logic [15:0] w;
    logic [7:0] a, f;
    logic ph;
    logic [2:0] fgc, bgc;
    if (!d) return 3'b000;
    col = xx / 8; row = yy / 16; ln = yy % 16; bt = xx % 8;
    w = ram[row * 80 + col];
    a = w[15:8];
    f = font[int'(w[7:0]) * 16 + ln];
    ph = ((fcnt >> 4) & 1) == 1;
    bgc = a[6:4];
    fgc = (a[7] && ph) ? bgc : a[2:0];
`ifdef VGA_TEXT_CURSOR_EN
    if (col == cx && row == cy && ln >= 14 && ph) return a[2:0];
`endif
    return f[7 - bt] ? fgc : bgc;
  endfunction

  task automatic step(input logic d, input int xx, input int yy, input logic fr, input logic rn);
    logic [2:0] e;
    @(negedge clk);
    if (rst_low) begin
      tests++;
      if ({r, g, b} !== 3'b000 || vaddr !== 11'd0 || faddr !== 12'd0) begin
        fails++;
        $display("FAIL reset_hold: rgb=%b vaddr=%0d faddr=%h, want 000/0/0", {r, g, b}, vaddr, faddr);
      end
    end else if (q.size() == 5) begin
      e = q.pop_front();
      tests++;
      if ({r, g, b} !== e) begin
        fails++;
        $display("FAIL pixel @%0t: rgb=%b, want %b", $time, {r, g, b}, e);
      end
    end
    de = d; x = 10'(xx); y = 10'(yy); frame = fr; reset_n = rn;
    cursor_x = 7'(cx); cursor_y = 5'(cy);
    if (!rn) begin
      q.delete();
      fcnt = 0;
      rst_low = 1;
    end else begin
      if (rst_low) repeat (4) q.push_back(3'b000);
      rst_low = 0;
      if (fr) fcnt = (fcnt + 1) % 32;
      q.push_back(model(d, xx, yy));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset;
    repeat (4) step(1, $urandom_range(639), $urandom_range(399), 1, 0);
    idle(6);
  endtask

  task automatic test_basic;
    ram[0] = 16'h0741;
    font[12'h410] = 8'h80;
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    idle(4);
    tests++;
    if ({r, g, b} !== 3'b111) begin fails++; $display("FAIL basic_on: rgb=%b, want 111", {r, g, b}); end
    idle(1);
    tests++;
    if ({r, g, b} !== 3'b000) begin fails++; $display("FAIL basic_off: rgb=%b, want 000", {r, g, b}); end
    idle(4);
  endtask

  task automatic test_addr;
    logic [7:0] c;
    c = ram[1999][7:0];
    step(1, 639, 399, 0, 1);
    idle(1);
    tests++;
    if (vaddr !== 11'd1999) begin fails++; $display("FAIL vaddr_max: vaddr=%0d, want 1999", vaddr); end
    idle(2);
    tests++;
    if (faddr !== {c, 4'hF}) begin fails++; $display("FAIL faddr_max: faddr=%h, want %h", faddr, {c, 4'hF}); end
    idle(4);
    tests++;
    if (vaddr !== 11'd1999 || faddr !== {c, 4'hF}) begin
      fails++;
      $display("FAIL addr_hold: vaddr=%0d faddr=%h, want 1999/%h", vaddr, faddr, {c, 4'hF});
    end
  endtask

  task automatic test_de_gap;
    for (int i = 0; i < 8; i++) ram[i] = {8'h25, 8'($urandom)};
    for (int xx = 0; xx < 64; xx++) step(xx != 30, xx, 5, 0, 1);
    idle(6);
  endtask

  task automatic test_random;
    cx = $urandom_range(79); cy = $urandom_range(24);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(7) != 0, $urandom_range(639), $urandom_range(399), 0, 1);
    idle(6);
  endtask

  task automatic test_frame_de;
    for (int i = 0; i < 200; i++) begin
      logic fr;
      fr = ($urandom_range(15) == 0) && (((fcnt + 1) >> 4 & 1) == (fcnt >> 4 & 1));
      step(1, $urandom_range(639), $urandom_range(399), fr, 1);
    end
    idle(6);
  endtask

  task automatic test_blink;
    step(0, 0, 0, 0, 0);
    ram[0] = 16'h9C42;
    font[12'h420] = 8'hFF;
    step(1, 0, 0, 0, 1);
    idle(5);
    tests++;
    if ({r, g, b} !== 3'b100) begin fails++; $display("FAIL blink_f0: rgb=%b, want 100", {r, g, b}); end
    repeat (15) step(0, 0, 0, 1, 1);
    idle(5);
    step(1, 0, 0, 0, 1);
    idle(5);
    tests++;
    if ({r, g, b} !== 3'b100) begin fails++; $display("FAIL blink_f15: rgb=%b, want 100", {r, g, b}); end
    step(0, 0, 0, 1, 1);
    idle(5);
    step(1, 0, 0, 0, 1);
    idle(5);
    tests++;
    if ({r, g, b} !== 3'b001) begin fails++; $display("FAIL blink_f16: rgb=%b, want 001", {r, g, b}); end
    repeat (16) step(0, 0, 0, 1, 1);
    idle(5);
    step(1, 0, 0, 0, 1);
    idle(5);
    tests++;
    if ({r, g, b} !== 3'b100) begin fails++; $display("FAIL blink_wrap: rgb=%b, want 100", {r, g, b}); end
  endtask

  task automatic test_cursor;
    cx = 3; cy = 2;
    ram[2 * 80 + 3] = 16'h1255;
    font[12'h55E] = 8'h00;
    font[12'h55F] = 8'h00;
    while (((fcnt >> 4) & 1) != 1) step(0, 0, 0, 1, 1);
    idle(6);
    for (int yy = 44; yy < 48; yy++)
      for (int xx = 16; xx < 40; xx++) step(1, xx, yy, 0, 1);
    idle(6);
    step(1, 24, 46, 0, 1);
    idle(5);
    tests++;
`ifdef VGA_TEXT_CURSOR_EN
    if ({r, g, b} !== 3'b010) begin fails++; $display("FAIL cursor_on: rgb=%b, want 010", {r, g, b}); end
`else
    if ({r, g, b} !== 3'b001) begin fails++; $display("FAIL cursor_off: rgb=%b, want 001", {r, g, b}); end
`endif
    idle(2);
  endtask

  task automatic test_reset_mid;
    ram[0] = 16'h9C42;
    font[12'h423] = 8'hFF;
    while (((fcnt >> 4) & 1) != 1) step(0, 0, 0, 1, 1);
    idle(6);
    for (int xx = 0; xx < 20; xx++) step(1, xx, 3, 0, 1);
    step(1, 20, 3, 0, 0);
    step(1, 21, 3, 0, 0);
    idle(3);
    for (int xx = 0; xx < 20; xx++) step(1, xx, 3, 0, 1);
    idle(6);
    step(1, 2, 3, 0, 1);
    idle(5);
    tests++;
    if ({r, g, b} !== 3'b100) begin fails++; $display("FAIL reset_counter: rgb=%b, want 100", {r, g, b}); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
    test_reset;
    test_basic;
    test_addr;
    test_de_gap;
    test_random;
    test_frame_de;
    test_blink;
    test_cursor;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
